// File: rtl/deser_pkg.sv
// Shared definitions for the bidirectional serial deserializer.
//   - state_t       : frame assembly FSM states (IDLE, COLLECT)
//   - DIR_*         : encodings of the dir / par_dir bit order
//   - frame_len()   : strobes per frame for a given data width
// Optional feature macro: DESER_PARITY_EN (adds one trailing even-parity bit
// to every frame).
package deser_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b1;
    localparam logic DIR_MSB_FIRST = 1'b0;

    // Number of serial strobes that make up one frame.
    function automatic int frame_len(input int width);
`ifdef DESER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Strobe counter for one frame: counts 0..FRAME_LEN-1 and flags the final bit.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : return to 0 (frame complete); wins over inc
//   inc       : count one strobe
//   last_bit  : the next strobe completes the frame
module deser_bit_counter #(
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last_bit
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign last_bit = (cnt_reg == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/bidir_serial_deserializer.sv
// Receive end of the bidirectional shift-register serial link.
// Assembles WIDTH-bit words from serial strobes in either bit order and hands
// them out through a one-word buffer with a valid/ready handshake.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ser_in, ser_vld : serial bit and its strobe
//   dir             : 1 = LSB first, 0 = MSB first; latched on a frame's first bit
//   par_out/par_vld : buffered word and its valid flag
//   par_rdy         : consumer accepts the word when par_vld & par_rdy
//   par_dir         : bit order of the word in par_out
//   overrun         : one-cycle pulse when a completed frame is dropped
//   par_err         : parity error of the word in par_out (0 without parity)
// Optional feature macro: DESER_PARITY_EN (trailing even-parity bit per frame).
module bidir_serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_vld,
    input  logic             dir,
    output logic [WIDTH-1:0] par_out,
    output logic             par_vld,
    input  logic             par_rdy,
    output logic             par_dir,
    output logic             overrun,
    output logic             par_err
);

    localparam int FRAME_LEN = frame_len(WIDTH);

    state_t           state_reg, state_next;
    logic             frame_dir_reg;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             last_bit;
    logic             cur_dir;
    logic             data_bit;
    logic             complete;
    logic             accept;
    logic             err_next;

    deser_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (complete),
        .inc      (ser_vld),
        .last_bit (last_bit)
    );

    assign complete = ser_vld && last_bit;
    // Buffer can take a new word if empty or being drained this very cycle.
    assign accept   = !par_vld || par_rdy;

    // The first bit of a frame uses dir directly; later bits use the latched copy.
    assign cur_dir = (state_reg == IDLE) ? dir : frame_dir_reg;

`ifdef DESER_PARITY_EN
    // Final strobe carries parity only; the data register already holds the word.
    assign data_bit = !last_bit;
    assign err_next = (^shift_reg) ^ ser_in;
`else
    assign data_bit = 1'b1;
    assign err_next = 1'b0;
`endif

    always_comb begin
        shift_next = shift_reg;
        if (ser_vld && data_bit) begin
            if (cur_dir == DIR_LSB_FIRST) begin
                shift_next = {ser_in, shift_reg[WIDTH-1:1]};
            end else begin
                shift_next = {shift_reg[WIDTH-2:0], ser_in};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ser_vld)  state_next = COLLECT;
            COLLECT: if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            frame_dir_reg <= DIR_MSB_FIRST;
            shift_reg     <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            if (state_reg == IDLE && ser_vld) begin
                frame_dir_reg <= dir;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out <= '0;
            par_vld <= 1'b0;
            par_dir <= DIR_MSB_FIRST;
            overrun <= 1'b0;
            par_err <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (accept) begin
                    par_out <= shift_next;
                    par_dir <= cur_dir;
                    par_err <= err_next;
                    par_vld <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (par_vld && par_rdy) begin
                par_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bidir_serial_deserializer.sv
module tb_bidir_serial_deserializer;

    localparam int W = 4;
`ifdef DESER_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_in;
    logic         ser_vld;
    logic         dir;
    logic         par_rdy;
    logic [W-1:0] par_out;
    logic         par_vld;
    logic         par_dir;
    logic         overrun;
    logic         par_err;

    bidir_serial_deserializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ser_in  (ser_in),
        .ser_vld (ser_vld),
        .dir     (dir),
        .par_out (par_out),
        .par_vld (par_vld),
        .par_rdy (par_rdy),
        .par_dir (par_dir),
        .overrun (overrun),
        .par_err (par_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: list of received bits of the current frame plus the
    // contents of the one-word output buffer.
    int           m_cnt;
    logic         m_bits [FLEN];
    logic         m_fdir;
    logic         m_vld;
    logic [W-1:0] m_out;
    logic         m_pdir;
    logic         m_err;
    logic         m_ovr;

    typedef struct {
        logic         d;
        logic [W-1:0] seq;   // seq[W-1] is sent first
        logic [W-1:0] exp;
    } frame_vec_t;

    frame_vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_fdir = 1'b0;
        m_vld = 1'b0;
        m_out = '0;
        m_pdir = 1'b0;
        m_err = 1'b0;
        m_ovr = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance model, compare after the edge.
    task automatic step(input logic v, input logic b, input logic d, input logic r);
        logic         comp;
        logic [W-1:0] w;
        logic         e;
        ser_vld = v;
        ser_in  = b;
        dir     = d;
        par_rdy = r;
        comp  = 1'b0;
        m_ovr = 1'b0;
        w = '0;
        e = 1'b0;
        if (v) begin
            if (m_cnt == 0) m_fdir = d;
            m_bits[m_cnt] = b;
            m_cnt++;
            if (m_cnt == FLEN) begin
                comp  = 1'b1;
                m_cnt = 0;
            end
        end
        if (comp) begin
            // Bit k of the frame lands at index k (LSB first) or W-1-k (MSB first).
            for (int k = 0; k < W; k++) begin
                if (m_fdir) w[k] = m_bits[k];
                else        w[W-1-k] = m_bits[k];
            end
`ifdef DESER_PARITY_EN
            for (int k = 0; k <= W; k++) e = e ^ m_bits[k];
`endif
            if (!m_vld || r) begin
                m_vld  = 1'b1;
                m_out  = w;
                m_pdir = m_fdir;
                m_err  = e;
                $display("xfer word=%h dir=%b err=%b delivered", w, m_fdir, e);
            end else begin
                m_ovr = 1'b1;
                $display("xfer word=%h dir=%b dropped (overrun)", w, m_fdir);
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("model_par_vld", 32'(par_vld), 32'(m_vld));
        chk("model_overrun", 32'(overrun), 32'(m_ovr));
        if (m_vld) begin
            chk("model_par_out", 32'(par_out), 32'(m_out));
            chk("model_par_dir", 32'(par_dir), 32'(m_pdir));
            chk("model_par_err", 32'(par_err), 32'(m_err));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ser_vld = 1'b0;
        ser_in = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_par_vld", 32'(par_vld), 32'd0);
        chk("reset_par_out", 32'(par_out), 32'd0);
        chk("reset_par_dir", 32'(par_dir), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_par_err", 32'(par_err), 32'd0);
    endtask

    // Sends a frame; the ready value on the final strobe is rdy_last.
    task automatic send_frame(input logic d, input logic [W-1:0] seq, input logic rdy,
                              input logic rdy_last, input logic pflip);
        for (int k = 0; k < W; k++) begin
            step(1'b1, seq[W-1-k], d, (k == FLEN-1) ? rdy_last : rdy);
        end
`ifdef DESER_PARITY_EN
        step(1'b1, (^seq) ^ pflip, d, rdy_last);
`else
        if (pflip) $display("note: parity flip ignored without parity");
`endif
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'b1011, 4'hD};
        tbl[1] = '{1'b0, 4'b1011, 4'hB};
        tbl[2] = '{1'b1, 4'b0110, 4'h6};
        tbl[3] = '{1'b0, 4'b0110, 4'h6};
        tbl[4] = '{1'b1, 4'b1100, 4'h3};
        tbl[5] = '{1'b0, 4'b1100, 4'hC};

        dir = 1'b0;
        par_rdy = 1'b0;
        do_reset();

        // Table: one frame each, ready high; word lives exactly one cycle.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].seq, 1'b1, 1'b1, 1'b0);
            chk("tbl_par_vld", 32'(par_vld), 32'd1);
            chk("tbl_par_out", 32'(par_out), 32'(tbl[i].exp));
            chk("tbl_par_dir", 32'(par_dir), 32'(tbl[i].d));
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("tbl_vld_drop", 32'(par_vld), 32'd0);
        end

        // Overrun: A=3 held, B=C dropped, then A drained once.
        send_frame(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        chk("ovr_a_out", 32'(par_out), 32'h3);
        send_frame(1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_keep_out", 32'(par_out), 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse_end", 32'(overrun), 32'd0);
        chk("ovr_still_vld", 32'(par_vld), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drained", 32'(par_vld), 32'd0);

        // Ready exactly on completion of the next frame: replace without overrun.
        send_frame(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
        chk("rep_hold_out", 32'(par_out), 32'h5);
        send_frame(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0);
        chk("rep_no_ovr", 32'(overrun), 32'd0);
        chk("rep_vld", 32'(par_vld), 32'd1);
        chk("rep_out", 32'(par_out), 32'hA);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset after two bits discards them.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        send_frame(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        chk("rst_mid_out", 32'(par_out), 32'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // dir toggles after the first bit; latched LSB-first order holds.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef DESER_PARITY_EN
        step(1'b1, 1'b1, 1'b0, 1'b1);
`endif
        chk("dirtog_out", 32'(par_out), 32'hD);
        chk("dirtog_dir", 32'(par_dir), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DESER_PARITY_EN
        send_frame(1'b1, 4'b1100, 1'b1, 1'b1, 1'b0);
        chk("par_ok_out", 32'(par_out), 32'h3);
        chk("par_ok_err", 32'(par_err), 32'd0);
        send_frame(1'b1, 4'b1100, 1'b1, 1'b1, 1'b1);
        chk("par_bad_out", 32'(par_out), 32'h3);
        chk("par_bad_err", 32'(par_err), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic against the model, including back-to-back frames.
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
